mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide sequencer for the 5-stage pipeline CPU. It owns the HI/LO registers and executes MULT/MULTU in a fixed 5-cycle latency and DIV/DIVU by 32-cycle restoring division. It tells the hazard unit when an MD-class instruction in D must stall. It sits beside the E-stage ALU; operands arrive already forwarded (after the forwardAE/forwardBE muxes).

## Interface

Parameters:
- MUL_LAT, 5, cycles from start to HI/LO update for multiply (≥1)

Ports (clock and reset first):
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  E stage holds MULT/MULTU/DIV/DIVU; already qualified by ~flushE
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  32  rs operand (multiplicand or dividend)
- b  in  32  rt operand (multiplier or divisor)
- hilo_we  in  1  MTHI/MTLO write strobe from E stage
- hilo_wsel  in  1  write target: 0 LO, 1 HI
- wdata  in  32  MTHI/MTLO data
- rd_sel  in  1  read select: 0 LO, 1 HI
- rdata  out  32  combinational HI or LO, for MFHI/MFLO
- md_useD  in  1  D stage holds any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  operation in flight
- stall_req  out  1  to hazard unit; ORed into stallF/stallD/flushE

## Operation

- State machine states:
  - IDLE
  - MUL: counter counts 1..MUL_LAT
  - DIV: 32 iterations
  - FIX: sign correction and HI/LO write
- Transitions:
  - IDLE→MUL on start with op[1]=0.
  - IDLE→DIV on start with op[1]=1.
  - MUL→IDLE when the counter reaches MUL_LAT; HI/LO are written on that edge.
  - DIV→FIX after iteration 32.
  - FIX→IDLE, writing HI/LO.
- Operand capture: a and b are registered at start. The inputs are don't-care after that.
- Multiply:
  - MULT computes the signed 64-bit product; MULTU the unsigned product.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Magnitudes are taken first: DIV uses |a| and |b|; DIVU uses raw values.
  - Unsigned restoring division, one quotient bit per cycle, 33-bit partial remainder.
  - FIX applies the signs: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Result: LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero (b=0), signed or unsigned: LO=0xFFFFFFFF, HI=a; full latency retained.
- MTHI/MTLO:
  - hilo_we writes the selected register at the edge, only in IDLE.
  - Ignored while busy.
  - If start and hilo_we are both high in IDLE, start wins and the write is dropped.
- start while busy is ignored; the hazard unit guarantees it does not occur.
- rdata reflects the registered HI/LO. The pre-operation value is visible while busy.
- stall_req = md_useD & (busy | start), combinational.
- Reset (rst=0, at any time, including mid-operation):
  - Aborts the operation; state IDLE.
  - HI=LO=0, counter=0.
  - busy=0, stall_req=0 while md_useD=0, rdata=0.

## Timing

- start sampled at edge k.
- busy high from after edge k; state machine outputs are registered.
- Multiply: HI/LO valid after edge k+MUL_LAT; busy falls at that same edge (MUL_LAT busy cycles).
- Divide: iterations on edges k+1..k+32, FIX at edge k+33. HI/LO valid and busy low after k+33 (33 busy cycles).
- Back-to-back: a start in the cycle after busy falls is accepted. An MFHI in D during the final busy cycle stalls; it enters E the next cycle and reads the new value.
- stall_req has zero latency relative to md_useD, busy and start. It must settle within the same cycle, because it gates the PC/IF-ID enables.
- rdata: combinational from HI/LO, updated the cycle after the writing edge.

## Test plan

- MULT a=0xFFFFFFFD (-3), b=5 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 5 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 33 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 → after 33 cycles LO=0xFFFFFFFF, HI=0x12345678.
- Hazard handling:
  - Issue DIV with md_useD=1 → stall_req high from the start cycle through the final busy cycle, then low.
  - MTLO 0xAA during busy → LO unaffected.
  - MTHI 0x55 in IDLE → HI=0x55 next cycle.
- Reset mid-operation: drive rst=0 asynchronously at iteration 10 of a DIV → busy=0, HI=LO=0 immediately. After release, a MULTU 3×4 → LO=0xC.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit bus: E-stage operands and MTxx/MFxx access to HI/LO,
// plus the hazard-unit handshake.
interface mdu_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_wsel;
  logic [31:0] wdata;
  logic        rd_sel;
  logic [31:0] rdata;
  logic        md_useD;
  logic        busy;
  logic        stall_req;

  modport master (
    output start, op, a, b, hilo_we, hilo_wsel, wdata, rd_sel, md_useD,
    input  rdata, busy, stall_req
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_wsel, wdata, rd_sel, md_useD,
    output rdata, busy, stall_req
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO owner and multiply/divide sequencer: fixed-latency multiply,
// 32-step restoring division with a final sign-correction cycle.
module mdu_ctrl #(
  parameter int MUL_LAT = 5
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (MUL_LAT > 32) ? MUL_LAT : 32;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   quo_q, quo_d, rem_q, rem_d;
  logic          sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic          busy;
  logic          sgn_in;
  logic [31:0]   a_mag, dvs;
  logic [63:0]   a_ext, b_ext, prod;
  logic [32:0]   part;

  assign sgn_in = ~bus.op[0];
  assign a_mag  = (sgn_in && bus.a[31]) ? -bus.a : bus.a;
  assign dvs    = (sgn_q && b_q[31]) ? -b_q : b_q;

  // Low 64 bits of a 64x64 product of sign/zero-extended operands equal the
  // signed/unsigned 32x32 product, so one multiplier serves MULT and MULTU.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign part  = {rem_q, quo_q[31]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          sgn_d = sgn_in;
          cnt_d = CW'(1);
          if (bus.op[1]) begin
            state_d = S_DIV;
            quo_d   = a_mag;
            rem_d   = '0;
            qneg_d  = sgn_in & (bus.a[31] ^ bus.b[31]);
            rneg_d  = sgn_in & bus.a[31];
            dz_d    = (bus.b == 32'd0);
          end else begin
            state_d = S_MUL;
          end
        end else if (bus.hilo_we) begin
          if (bus.hilo_wsel) hi_d = bus.wdata;
          else               lo_d = bus.wdata;
        end
      end

      S_MUL: begin
        if (cnt_q == CW'(MUL_LAT)) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DIV: begin
        // Dividend shifts out of quo_q as quotient bits shift in.
        if (part >= {1'b0, dvs}) begin
          rem_d = 32'(part - {1'b0, dvs});
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = part[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == CW'(32)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_FIX: begin
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.busy      = busy;
  assign bus.stall_req = bus.md_useD & (busy | bus.start);
  assign bus.rdata     = bus.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised bench for mdu_ctrl: reference model of HI/LO and busy window
// checked every cycle, plus literal results for the directed operations.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 5;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference result as {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_result(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, p, q, r;
    if (!o[1]) begin
      if (!o[0]) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
      end else begin
        sx = longint'({32'b0, x});
        sy = longint'({32'b0, y});
      end
      p = sx * sy;
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (bus.start) begin
      m_res  <= ref_result(bus.op, bus.a, bus.b);
      m_left <= bus.op[1] ? 33 : MUL_LAT;
    end else if (bus.hilo_we) begin
      if (bus.hilo_wsel) m_hi <= bus.wdata;
      else               m_lo <= bus.wdata;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic obs_busy, obs_stall;

  task automatic check();
    logic        eb, es;
    logic [31:0] er;
    eb = (m_left != 0);
    es = bus.md_useD & (eb | bus.start);
    er = bus.rd_sel ? m_hi : m_lo;
    cmp("busy",      {31'b0, bus.busy},      {31'b0, eb});
    cmp("stall_req", {31'b0, bus.stall_req}, {31'b0, es});
    cmp("rdata",     bus.rdata,              er);
  endtask

  task automatic settle();
    #1;
    check();
    obs_busy  = bus.busy;
    obs_stall = bus.stall_req;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.rd_sel = 1'b1; #1; hi = bus.rdata;
    bus.rd_sel = 1'b0; #1; lo = bus.rdata;
  endtask

  task automatic drive_idle_noise();
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.hilo_we   = ($urandom_range(0, 3) == 0);
    bus.hilo_wsel = 1'($urandom);
    bus.wdata     = $urandom;
    bus.rd_sel    = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle_noise();
      bus.md_useD = 1'($urandom);
      settle();
      next_cycle();
    end
    bus.hilo_we = 1'b0;
  endtask

  // Issues one operation and returns once busy has fallen, still inside the
  // first idle cycle so a following start is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic md, input bit poke_lo,
                        output int bc, output int sc,
                        output logic [31:0] hi, output logic [31:0] lo);
    bit done;
    bc   = 0;
    sc   = 0;
    done = 1'b0;
    bus.start     = 1'b1;
    bus.op        = o;
    bus.a         = x;
    bus.b         = y;
    bus.md_useD   = md;
    bus.hilo_we   = 1'($urandom);
    bus.hilo_wsel = 1'($urandom);
    bus.wdata     = $urandom;
    bus.rd_sel    = 1'($urandom);
    settle();
    sc += int'(obs_stall);
    next_cycle();
    for (int i = 0; i < 40; i++) begin
      drive_idle_noise();
      if (poke_lo) begin
        bus.hilo_we   = 1'b1;
        bus.hilo_wsel = 1'b0;
        bus.wdata     = 32'h0000_00AA;
      end
      settle();
      if (!obs_busy) begin
        done = 1'b1;
        bus.hilo_we = 1'b0;
        break;
      end
      bc++;
      sc += int'(obs_stall);
      next_cycle();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL op_timeout: busy still high after 40 cycles, required low");
      bus.hilo_we = 1'b0;
    end
    read_hilo(hi, lo);
    $display("op=%0d a=%h b=%h md=%0b busy=%0d stall=%0d -> hi=%h lo=%h",
             o, x, y, md, bc, sc, hi, lo);
  endtask

  int          bc, sc;
  logic [31:0] hi, lo;
  logic [1:0]  ro;
  logic [31:0] rx, ry;

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hilo_we = 1'b0; bus.hilo_wsel = 1'b0; bus.wdata = '0;
    bus.rd_sel = 1'b0; bus.md_useD = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_busy",  {31'b0, bus.busy},      32'd0);
    cmp("rst_stall", {31'b0, bus.stall_req}, 32'd0);
    read_hilo(hi, lo);
    cmp("rst_hi", hi, 32'd0);
    cmp("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("mult_busy_len", bc, 32'd5);
    cmp("mult_hi", hi, 32'hFFFF_FFFF);
    cmp("mult_lo", lo, 32'hFFFF_FFF1);
    cmp("model_mult_lo", m_lo, 32'hFFFF_FFF1);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("multu_hi", hi, 32'hFFFF_FFFE);
    cmp("multu_lo", lo, 32'h0000_0001);
    cmp("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, bc, sc, hi, lo);
    cmp("div_busy_len", bc, 32'd33);
    cmp("div_stall_len", sc, 32'd34);
    cmp("div_hi", hi, 32'hFFFF_FFFF);
    cmp("div_lo", lo, 32'hFFFF_FFFD);
    cmp("model_div_lo", m_lo, 32'hFFFF_FFFD);

    run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("divu0_busy_len", bc, 32'd33);
    cmp("divu0_hi", hi, 32'h1234_5678);
    cmp("divu0_lo", lo, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("divovf_hi", hi, 32'd0);
    cmp("divovf_lo", lo, 32'h8000_0000);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("div0_hi", hi, 32'hFFFF_FFF9);
    cmp("div0_lo", lo, 32'hFFFF_FFFF);

    // MTLO attempted on every busy cycle must not land.
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1, bc, sc, hi, lo);
    cmp("poke_hi", hi, 32'd2);
    cmp("poke_lo", lo, 32'd14);

    bus.start = 1'b0; bus.hilo_we = 1'b1; bus.hilo_wsel = 1'b1; bus.wdata = 32'h55;
    settle();
    next_cycle();
    bus.hilo_we = 1'b0;
    settle();
    read_hilo(hi, lo);
    cmp("mthi_hi", hi, 32'h0000_0055);
    cmp("mthi_lo", lo, 32'd14);
    next_cycle();

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
    bus.md_useD = 1'b0; bus.hilo_we = 1'b0;
    settle();
    next_cycle();
    bus.start = 1'b0;
    repeat (10) begin
      settle();
      next_cycle();
    end
    #3 rst = 1'b0;
    #1;
    cmp("abort_busy",  {31'b0, bus.busy},      32'd0);
    cmp("abort_stall", {31'b0, bus.stall_req}, 32'd0);
    read_hilo(hi, lo);
    cmp("abort_hi", hi, 32'd0);
    cmp("abort_lo", lo, 32'd0);
    next_cycle();
    rst = 1'b1;
    settle();
    next_cycle();
    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, bc, sc, hi, lo);
    cmp("post_rst_hi", hi, 32'd0);
    cmp("post_rst_lo", lo, 32'h0000_000C);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 20));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      run_op(ro, rx, ry, 1'($urandom), 1'b0, bc, sc, hi, lo);
      cmp("rand_busy_len", bc, ro[1] ? 32'd33 : 32'(MUL_LAT));
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
